toggle_pulse_gen: RTL and testbench

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

---
 rtl/toggle_pulse_gen.sv | 122 ++++++++++++
 tb/tb_toggle_pulse_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: timed generator of one-cycle toggle-enable pulses.
// A sequence starts on an accepted start. It then emits t_out every
// P cycles, where P is the latched period and a period of 0 counts as 1.
// Continuous mode runs until stop. Burst mode finishes after burst_len
// pulses and signals completion with a one-cycle done.
// Every output is taken straight from a flop.
module toggle_pulse_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] burst_len,
    output logic             t_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] burst_q, burst_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;     // cycles elapsed since the last pulse (or since start)
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             t_out_q, t_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, latch and registered-output decode
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        burst_d  = burst_q;
        mode_d   = mode_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        t_out_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // A simultaneous stop vetoes the start.
                if (start && !stop) begin
                    state_d  = RUN;
                    period_d = (period == ZERO) ? ONE : period;
                    burst_d  = burst_len;
                    mode_d   = mode;
                    cyc_d    = ZERO;
                    cnt_d    = ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort: a pulse due on this edge is dropped and the count is held.
                    state_d = IDLE;
                end else if (mode_q && (cnt_q == burst_q)) begin
                    // Burst complete. This check comes first so that burst_len = 0
                    // finishes without emitting any pulse.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if ((cyc_q + ONE) == period_q) begin
                    t_out_d = 1'b1;
                    cnt_d   = cnt_q + ONE;
                    cyc_d   = ZERO;
                end else begin
                    cyc_d = cyc_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    // State, latched parameters, counters and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= ZERO;
            burst_q  <= ZERO;
            mode_q   <= 1'b0;
            cyc_q    <= ZERO;
            cnt_q    <= ZERO;
            t_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            burst_q  <= burst_d;
            mode_q   <= mode_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            t_out_q  <= t_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign t_out     = t_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed self-checking bench for toggle_pulse_gen.
// Each check samples the outputs 1 ns after a rising edge. Expected
// values are worked out by hand from the edge numbering that starts at
// E0, the edge on which start is accepted.
module tb_toggle_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] period;
    logic [7:0] burst_len;
    logic       t_out;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;
    logic tff_q;

    toggle_pulse_gen #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .burst_len (burst_len),
        .t_out     (t_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // T flip-flop driven by t_out for the closed-loop test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tff_q <= 1'b0;
        else if (t_out) tff_q <= ~tff_q;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] cnt);
        chk({tag, "_tout"}, {31'd0, t_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy},  32'd0);
        chk({tag, "_done"}, {31'd0, done},  32'd0);
        chk({tag, "_cnt"},  {24'd0, pulse_cnt}, {24'd0, cnt});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = 8'd0; burst_len = 8'd0;
        #2;
        chk_idle("reset", 8'd0);
        #10 rst_n = 1'b1;
        tick(); tick();
        chk_idle("post_reset", 8'd0);

        // Continuous mode, period 3; inputs changed mid-run must be ignored
        mode = 1'b0; period = 8'd3; start = 1'b1;
        tick();                                   // E0
        start = 1'b0; period = 8'd1; mode = 1'b1; burst_len = 8'd1;
        chk("cont_busy0", {31'd0, busy}, 32'd1);
        chk("cont_cnt0", {24'd0, pulse_cnt}, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("cont_tout", {31'd0, t_out}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("cont_cnt", {24'd0, pulse_cnt}, k / 3);
            chk("cont_busy", {31'd0, busy}, 32'd1);
        end
        stop = 1'b1;
        tick();                                   // E10
        stop = 1'b0;
        chk_idle("cont_stop", 8'd3);

        // Normal burst: period 2, burst_len 4
        mode = 1'b1; period = 8'd2; burst_len = 8'd4; start = 1'b1;
        tick();                                   // E0
        start = 1'b0; mode = 1'b0;
        chk("burst_cnt0", {24'd0, pulse_cnt}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("burst_tout", {31'd0, t_out}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("burst_cnt", {24'd0, pulse_cnt}, k / 2);
            chk("burst_busy", {31'd0, busy}, 32'd1);
            chk("burst_done", {31'd0, done}, 32'd0);
        end
        tick();                                   // E9
        chk("burst_e9_done", {31'd0, done}, 32'd1);
        chk("burst_e9_busy", {31'd0, busy}, 32'd0);
        chk("burst_e9_tout", {31'd0, t_out}, 32'd0);
        tick();                                   // E10
        chk_idle("burst_e10", 8'd4);

        // Period 0 acts as 1: a pulse every cycle starting at E1
        mode = 1'b0; period = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("p0_tout0", {31'd0, t_out}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("p0_tout", {31'd0, t_out}, 32'd1);
            chk("p0_cnt", {24'd0, pulse_cnt}, k);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("p0_stop", 8'd4);

        // burst_len 0: done after E1 with no pulse, then start+stop together in DONE
        mode = 1'b1; period = 8'd2; burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bl0_busy0", {31'd0, busy}, 32'd1);
        tick();                                   // E1
        chk("bl0_done", {31'd0, done}, 32'd1);
        chk("bl0_busy", {31'd0, busy}, 32'd0);
        chk("bl0_tout", {31'd0, t_out}, 32'd0);
        chk("bl0_cnt", {24'd0, pulse_cnt}, 32'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_idle("done_startstop", 8'd0);

        // Stop on the edge where a pulse falls due
        mode = 1'b0; period = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                           // E1, E2
        stop = 1'b1;
        tick();                                   // E3: pulse due, but stop wins
        stop = 1'b0;
        chk_idle("stop_due", 8'd0);
        tick();
        chk_idle("stop_due_after", 8'd0);

        // start and stop together in IDLE leave the FSM in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_idle("idle_startstop", 8'd0);
        tick();
        chk_idle("idle_startstop2", 8'd0);

        // Restart accepted while in DONE
        mode = 1'b1; period = 8'd1; burst_len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();                                   // E1 pulse
        chk("rs_tout", {31'd0, t_out}, 32'd1);
        tick();                                   // E2 DONE
        chk("rs_done", {31'd0, done}, 32'd1);
        mode = 1'b0; period = 8'd5; start = 1'b1;
        tick();                                   // restart from DONE
        start = 1'b0;
        chk("rs_busy", {31'd0, busy}, 32'd1);
        chk("rs_cnt", {24'd0, pulse_cnt}, 32'd0);
        chk("rs_done2", {31'd0, done}, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("rs_stop", 8'd0);

        // Reset asserted mid-run, between clock edges
        mode = 1'b0; period = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                           // E2 pulse
        chk("mr_cnt_pre", {24'd0, pulse_cnt}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_idle("mr_async", 8'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_idle("mr_after", 8'd0);
        end

        // Closed loop: burst of 5 pulses at period 1 feeding a T flip-flop
        chk("tff_init", {31'd0, tff_q}, 32'd0);
        mode = 1'b1; period = 8'd1; burst_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (t_out) pulses++;
        end
        chk("tff_pulses", pulses, 32'd5);
        chk("tff_cnt", {24'd0, pulse_cnt}, 32'd5);
        chk("tff_q", {31'd0, tff_q}, 32'd1);
        chk("tff_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
